// File: rtl/mem_port2_arbiter_pkg.sv
// Shared memory-port types: access size, request bundle, and the I/O window base.
package otter_mem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef struct packed {
    logic      we;
    logic [31:0] addr;
    logic [31:0] din;
    mem_size_t size;
    logic      sign;
  } mem_req_t;

  localparam logic [31:0] IO_BASE = 32'h1100_0000;

endpackage

// File: rtl/mem_port2_arbiter_if.sv
// One requester's view of memory port 2: request fields in, grant and read response out.
interface mem_port2_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] din;
  logic [1:0]  size;
  logic        sign;
  logic        gnt;
  logic [31:0] rdata;
  logic        rvalid;

  modport master (output req, we, addr, din, size, sign, input gnt, rdata, rvalid);
  modport slave  (input req, we, addr, din, size, sign, output gnt, rdata, rvalid);
endinterface

// File: rtl/mem_port2_arbiter_starve_cnt.sv
// Counts consecutive denied DMA cycles and raises force_dma once the limit is reached.
module arb_starve_cnt #(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic RST,
  input  logic dma_req,
  input  logic dma_gnt,
  output logic force_dma
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt;

  // A grant or a withdrawn request restarts the count; it sticks at LIMIT until DMA wins.
  always_ff @(posedge clk) begin
    if (RST || !dma_req || dma_gnt)
      wait_cnt <= '0;
    else if (wait_cnt != LIMIT)
      wait_cnt <= wait_cnt + CNT_W'(1);
  end

  assign force_dma = (wait_cnt == LIMIT);

endmodule

// File: rtl/mem_port2_arbiter.sv
// Shares memory port 2 between the CPU data path and a DMA master: CPU-first priority
// with a starvation guard, and 1-cycle read data steered back to whoever issued it.
module mem_port2_arbiter
  import otter_mem_pkg::*;
#(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                RST,
  mem_port2_arbiter_if.slave  cpu,
  mem_port2_arbiter_if.slave  dma,
  output logic                mem_rden2,
  output logic                mem_we2,
  output logic [31:0]         mem_addr2,
  output logic [31:0]         mem_din2,
  output logic [1:0]          mem_size,
  output logic                mem_sign,
  input  logic [31:0]         mem_dout2
);

  logic     force_dma;
  logic     dma_gnt;
  logic     cpu_gnt;
  mem_req_t sel;
  logic     rd_pending;
  logic     rd_owner;

  arb_starve_cnt #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) u_cnt (
    .clk       (clk),
    .RST       (RST),
    .dma_req   (dma.req),
    .dma_gnt   (dma_gnt),
    .force_dma (force_dma)
  );

  assign dma_gnt = dma.req & (~cpu.req | force_dma);
  assign cpu_gnt = cpu.req & ~dma_gnt;
  assign cpu.gnt = cpu_gnt;
  assign dma.gnt = dma_gnt;

  // An idle port drives zeros so nothing downstream latches stale addresses.
  always_comb begin
    sel = '0;
    if (dma_gnt)
      sel = '{we: dma.we, addr: dma.addr, din: dma.din, size: mem_size_t'(dma.size), sign: dma.sign};
    else if (cpu_gnt)
      sel = '{we: cpu.we, addr: cpu.addr, din: cpu.din, size: mem_size_t'(cpu.size), sign: cpu.sign};
  end

  assign mem_rden2 = (cpu_gnt | dma_gnt) & ~sel.we;
  assign mem_we2   = (cpu_gnt | dma_gnt) & sel.we;
  assign mem_addr2 = sel.addr;
  assign mem_din2  = sel.din;
  assign mem_size  = sel.size;
  assign mem_sign  = sel.sign;

  always_ff @(posedge clk) begin
    if (RST) begin
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      rd_pending <= mem_rden2;
      rd_owner   <= dma_gnt;
    end
  end

  assign cpu.rvalid = rd_pending & ~rd_owner;
  assign dma.rvalid = rd_pending & rd_owner;
  assign cpu.rdata  = cpu.rvalid ? mem_dout2 : 32'h0;
  assign dma.rdata  = dma.rvalid ? mem_dout2 : 32'h0;

endmodule

// File: tb/tb_mem_port2_arbiter.sv
// Directed checks of grant priority, starvation forcing, port muxing and read steering.
module tb_mem_port2_arbiter;

  logic        clk = 1'b0;
  logic        RST;
  logic [31:0] mem_dout2;
  logic        mem_rden2, mem_we2, mem_sign;
  logic [31:0] mem_addr2, mem_din2;
  logic [1:0]  mem_size;

  logic        m1_rden2, m1_we2, m1_sign;
  logic [31:0] m1_addr2, m1_din2;
  logic [1:0]  m1_size;

  int checks   = 0;
  int failures = 0;

  mem_port2_arbiter_if cpu_if ();
  mem_port2_arbiter_if dma_if ();
  mem_port2_arbiter_if cpu1_if ();
  mem_port2_arbiter_if dma1_if ();

  always #5 clk = ~clk;

  mem_port2_arbiter #(.MAX_WAIT(8), .CNT_W(8)) dut (
    .clk(clk), .RST(RST), .cpu(cpu_if.slave), .dma(dma_if.slave),
    .mem_rden2(mem_rden2), .mem_we2(mem_we2), .mem_addr2(mem_addr2),
    .mem_din2(mem_din2), .mem_size(mem_size), .mem_sign(mem_sign),
    .mem_dout2(mem_dout2)
  );

  mem_port2_arbiter #(.MAX_WAIT(1), .CNT_W(8)) dut1 (
    .clk(clk), .RST(RST), .cpu(cpu1_if.slave), .dma(dma1_if.slave),
    .mem_rden2(m1_rden2), .mem_we2(m1_we2), .mem_addr2(m1_addr2),
    .mem_din2(m1_din2), .mem_size(m1_size), .mem_sign(m1_sign),
    .mem_dout2(mem_dout2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cpu(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] din, input logic [1:0] size, input logic sign);
    cpu_if.req = req; cpu_if.we = we; cpu_if.addr = addr;
    cpu_if.din = din; cpu_if.size = size; cpu_if.sign = sign;
  endtask

  task automatic drive_dma(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] din, input logic [1:0] size, input logic sign);
    dma_if.req = req; dma_if.we = we; dma_if.addr = addr;
    dma_if.din = din; dma_if.size = size; dma_if.sign = sign;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    drive_cpu(0, 0, 0, 0, 0, 0);
    drive_dma(0, 0, 0, 0, 0, 0);
    cpu1_if.req = 0; cpu1_if.we = 0; cpu1_if.addr = 0; cpu1_if.din = 0; cpu1_if.size = 0; cpu1_if.sign = 0;
    dma1_if.req = 0; dma1_if.we = 0; dma1_if.addr = 0; dma1_if.din = 0; dma1_if.size = 0; dma1_if.sign = 0;
    mem_dout2 = 32'h0;
    step();
    step();
    RST = 1'b0;
    #1;
    checks++;
    if (cpu_if.rvalid !== 1'b0 || dma_if.rvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_rvalid cpu=%b dma=%b expected 0 0", cpu_if.rvalid, dma_if.rvalid);
    end
    checks++;
    if (mem_rden2 !== 1'b0 || mem_we2 !== 1'b0 || mem_addr2 !== 32'h0) begin
      failures++;
      $display("FAIL reset_port rden=%b we=%b addr=%h expected 0 0 0", mem_rden2, mem_we2, mem_addr2);
    end
    checks++;
    if (dut.u_cnt.wait_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_cnt got=%0d expected 0", dut.u_cnt.wait_cnt);
    end
  endtask

  task automatic test_cpu_read();
    step();
    drive_cpu(1, 0, 32'h0000_6000, 32'h0, 2'd2, 1'b0);
    #1;
    checks++;
    if (cpu_if.gnt !== 1'b1 || dma_if.gnt !== 1'b0 || mem_rden2 !== 1'b1 || mem_we2 !== 1'b0) begin
      failures++;
      $display("FAIL cpu_read_grant cgnt=%b dgnt=%b rden=%b we=%b expected 1 0 1 0",
               cpu_if.gnt, dma_if.gnt, mem_rden2, mem_we2);
    end
    checks++;
    if (mem_addr2 !== 32'h0000_6000 || mem_size !== 2'd2) begin
      failures++;
      $display("FAIL cpu_read_addr addr=%h size=%0d expected 00006000 2", mem_addr2, mem_size);
    end
    step();
    drive_cpu(0, 0, 0, 0, 0, 0);
    mem_dout2 = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (cpu_if.rvalid !== 1'b1 || cpu_if.rdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL cpu_read_data rvalid=%b rdata=%h expected 1 deadbeef", cpu_if.rvalid, cpu_if.rdata);
    end
    checks++;
    if (dma_if.rvalid !== 1'b0 || dma_if.rdata !== 32'h0) begin
      failures++;
      $display("FAIL cpu_read_cross dma_rvalid=%b dma_rdata=%h expected 0 0", dma_if.rvalid, dma_if.rdata);
    end
    step();
    mem_dout2 = 32'h0;
    #1;
    checks++;
    if (cpu_if.rvalid !== 1'b0) begin
      failures++;
      $display("FAIL cpu_read_once rvalid=%b expected 0", cpu_if.rvalid);
    end
  endtask

  task automatic test_dma_store();
    drive_dma(1, 1, 32'h0000_8000, 32'h1234_5678, 2'd2, 1'b0);
    #1;
    checks++;
    if (dma_if.gnt !== 1'b1 || cpu_if.gnt !== 1'b0 || mem_we2 !== 1'b1 || mem_rden2 !== 1'b0) begin
      failures++;
      $display("FAIL dma_store_grant dgnt=%b cgnt=%b we=%b rden=%b expected 1 0 1 0",
               dma_if.gnt, cpu_if.gnt, mem_we2, mem_rden2);
    end
    checks++;
    if (mem_addr2 !== 32'h0000_8000 || mem_din2 !== 32'h1234_5678 || mem_size !== 2'd2) begin
      failures++;
      $display("FAIL dma_store_bus addr=%h din=%h size=%0d expected 00008000 12345678 2",
               mem_addr2, mem_din2, mem_size);
    end
    step();
    drive_dma(0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (cpu_if.rvalid !== 1'b0 || dma_if.rvalid !== 1'b0) begin
      failures++;
      $display("FAIL dma_store_norvalid cpu=%b dma=%b expected 0 0", cpu_if.rvalid, dma_if.rvalid);
    end
    checks++;
    if (mem_we2 !== 1'b0 || mem_din2 !== 32'h0 || mem_size !== 2'd0 || mem_sign !== 1'b0) begin
      failures++;
      $display("FAIL idle_port we=%b din=%h size=%0d sign=%b expected 0 0 0 0",
               mem_we2, mem_din2, mem_size, mem_sign);
    end
  endtask

  task automatic test_contention();
    step();
    drive_cpu(1, 0, 32'h0000_0100, 32'h0, 2'd2, 1'b1);
    drive_dma(1, 0, 32'h0000_0200, 32'h0, 2'd1, 1'b0);
    for (int cyc = 0; cyc < 18; cyc++) begin
      #1;
      checks++;
      if (dma_if.gnt !== ((cyc % 9) == 8) || cpu_if.gnt !== ((cyc % 9) != 8)) begin
        failures++;
        $display("FAIL contention_gnt cyc=%0d dgnt=%b cgnt=%b expected dgnt=%b",
                 cyc, dma_if.gnt, cpu_if.gnt, (cyc % 9) == 8);
      end
      checks++;
      if (mem_addr2 !== (((cyc % 9) == 8) ? 32'h0000_0200 : 32'h0000_0100)) begin
        failures++;
        $display("FAIL contention_addr cyc=%0d addr=%h", cyc, mem_addr2);
      end
      checks++;
      if (dut.u_cnt.wait_cnt !== 8'(cyc % 9)) begin
        failures++;
        $display("FAIL contention_cnt cyc=%0d got=%0d expected %0d", cyc, dut.u_cnt.wait_cnt, cyc % 9);
      end
      checks++;
      if (dma_if.rvalid !== (cyc > 0 && ((cyc - 1) % 9) == 8)) begin
        failures++;
        $display("FAIL contention_route cyc=%0d dma_rvalid=%b", cyc, dma_if.rvalid);
      end
      step();
    end
    drive_cpu(0, 0, 0, 0, 0, 0);
    drive_dma(0, 0, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_interleaved();
    drive_cpu(1, 0, 32'h0000_00A0, 32'h0, 2'd2, 1'b0);
    step();
    drive_cpu(0, 0, 0, 0, 0, 0);
    drive_dma(1, 0, 32'h0000_00B0, 32'h0, 2'd2, 1'b0);
    mem_dout2 = 32'h1111_1111;
    #1;
    checks++;
    if (cpu_if.rvalid !== 1'b1 || cpu_if.rdata !== 32'h1111_1111 || dma_if.rvalid !== 1'b0 || dma_if.rdata !== 32'h0) begin
      failures++;
      $display("FAIL interleave_c1 crv=%b crd=%h drv=%b drd=%h expected 1 11111111 0 0",
               cpu_if.rvalid, cpu_if.rdata, dma_if.rvalid, dma_if.rdata);
    end
    checks++;
    if (dma_if.gnt !== 1'b1 || mem_addr2 !== 32'h0000_00B0) begin
      failures++;
      $display("FAIL interleave_dgnt dgnt=%b addr=%h expected 1 000000b0", dma_if.gnt, mem_addr2);
    end
    step();
    drive_dma(0, 0, 0, 0, 0, 0);
    mem_dout2 = 32'h2222_2222;
    #1;
    checks++;
    if (dma_if.rvalid !== 1'b1 || dma_if.rdata !== 32'h2222_2222 || cpu_if.rvalid !== 1'b0 || cpu_if.rdata !== 32'h0) begin
      failures++;
      $display("FAIL interleave_c2 drv=%b drd=%h crv=%b crd=%h expected 1 22222222 0 0",
               dma_if.rvalid, dma_if.rdata, cpu_if.rvalid, cpu_if.rdata);
    end
    step();
    mem_dout2 = 32'h0;
  endtask

  task automatic test_reset_mid_read();
    drive_cpu(1, 0, 32'h0000_0040, 32'h0, 2'd2, 1'b0);
    drive_dma(1, 0, 32'h0000_0080, 32'h0, 2'd2, 1'b0);
    step();
    step();
    step();
    RST = 1'b1;
    drive_dma(0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (cpu_if.gnt !== 1'b1 || mem_rden2 !== 1'b1) begin
      failures++;
      $display("FAIL rst_comb_gnt cgnt=%b rden=%b expected 1 1", cpu_if.gnt, mem_rden2);
    end
    step();
    drive_cpu(0, 0, 0, 0, 0, 0);
    mem_dout2 = 32'h3333_3333;
    #1;
    checks++;
    if (cpu_if.rvalid !== 1'b0 || cpu_if.rdata !== 32'h0) begin
      failures++;
      $display("FAIL rst_drop_c1 rvalid=%b rdata=%h expected 0 0", cpu_if.rvalid, cpu_if.rdata);
    end
    checks++;
    if (dut.u_cnt.wait_cnt !== 8'd0) begin
      failures++;
      $display("FAIL rst_cnt got=%0d expected 0", dut.u_cnt.wait_cnt);
    end
    step();
    RST = 1'b0;
    #1;
    checks++;
    if (cpu_if.rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rst_drop_c2 rvalid=%b expected 0", cpu_if.rvalid);
    end
    mem_dout2 = 32'h0;
    step();
  endtask

  task automatic test_withdraw();
    drive_cpu(1, 0, 32'h0000_0010, 32'h0, 2'd2, 1'b0);
    drive_dma(1, 0, 32'h0000_0020, 32'h0, 2'd2, 1'b0);
    for (int cyc = 0; cyc < 5; cyc++) begin
      #1;
      checks++;
      if (dma_if.gnt !== 1'b0) begin
        failures++;
        $display("FAIL withdraw_pre cyc=%0d dgnt=%b expected 0", cyc, dma_if.gnt);
      end
      step();
    end
    drive_dma(0, 0, 0, 0, 0, 0);
    step();
    drive_dma(1, 0, 32'h0000_0020, 32'h0, 2'd2, 1'b0);
    #1;
    checks++;
    if (dut.u_cnt.wait_cnt !== 8'd0) begin
      failures++;
      $display("FAIL withdraw_clear got=%0d expected 0", dut.u_cnt.wait_cnt);
    end
    for (int cyc = 0; cyc < 9; cyc++) begin
      #1;
      checks++;
      if (dma_if.gnt !== (cyc == 8)) begin
        failures++;
        $display("FAIL withdraw_post cyc=%0d dgnt=%b expected %b", cyc, dma_if.gnt, cyc == 8);
      end
      step();
    end
    drive_cpu(0, 0, 0, 0, 0, 0);
    drive_dma(0, 0, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_max_wait1();
    cpu1_if.req = 1; cpu1_if.addr = 32'h0000_0300; cpu1_if.size = 2'd2;
    dma1_if.req = 1; dma1_if.addr = 32'h0000_0400; dma1_if.size = 2'd0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      #1;
      checks++;
      if (dma1_if.gnt !== cyc[0] || cpu1_if.gnt !== !cyc[0]) begin
        failures++;
        $display("FAIL maxwait1 cyc=%0d dgnt=%b cgnt=%b expected dgnt=%b", cyc, dma1_if.gnt, cpu1_if.gnt, cyc[0]);
      end
      checks++;
      if (m1_addr2 !== (cyc[0] ? 32'h0000_0400 : 32'h0000_0300)) begin
        failures++;
        $display("FAIL maxwait1_addr cyc=%0d addr=%h", cyc, m1_addr2);
      end
      step();
    end
    cpu1_if.req = 0;
    dma1_if.req = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_store();
    test_contention();
    test_interleaved();
    test_reset_mid_read();
    test_withdraw();
    test_max_wait1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port2_arbiter.md
Name: mem_port2_arbiter

Overview:
- Shares the Memory data port (port 2: MEM_RDEN2/MEM_WE2/MEM_ADDR2/MEM_DIN2/MEM_SIZE/MEM_SIGN, MEM_DOUT2) between two requesters: the CPU load/store path and a DMA master.
- Priority is fixed to the CPU, with a starvation guard that forces a DMA grant after MAX_WAIT lost cycles.
- Routes the 1-cycle-latency read data back to the requester that issued the read.
- Sits between OTTER_MCU's data-side signals and the Memory instance. A low cpu_gnt stalls the CPU control FSM.

Parameters:
- MAX_WAIT, 8, consecutive denied DMA cycles before DMA is forced to win (1..255).
- CNT_W, 8, width of the starvation counter; must hold MAX_WAIT.

Ports:
- clk  in  1  system clock, rising edge
- RST  in  1  synchronous active-high reset
- cpu_req  in  1  CPU requests a data access this cycle
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address
- cpu_din  in  32  store data
- cpu_size  in  2  0 = byte, 1 = half, 2 = word
- cpu_sign  in  1  1 = zero-extend load (ir[14] convention)
- cpu_gnt  out  1  CPU access issued this cycle
- cpu_rdata  out  32  load data
- cpu_rvalid  out  1  cpu_rdata valid
- dma_req, dma_we, dma_addr, dma_din, dma_size, dma_sign  in  1/1/32/32/2/1  same meaning for DMA
- dma_gnt  out  1  DMA access issued this cycle
- dma_rdata  out  32  load data
- dma_rvalid  out  1  dma_rdata valid
- mem_rden2  out  1  to MEM_RDEN2
- mem_we2  out  1  to MEM_WE2
- mem_addr2  out  32  to MEM_ADDR2
- mem_din2  out  32  to MEM_DIN2
- mem_size  out  2  to MEM_SIZE
- mem_sign  out  1  to MEM_SIGN
- mem_dout2  in  32  from MEM_DOUT2, valid 1 cycle after mem_rden2

Behaviour:
- Grant decision is combinational and made in the same cycle as the request.
  - force_dma = (wait_cnt == MAX_WAIT).
  - dma_gnt = dma_req & (~cpu_req | force_dma).
  - cpu_gnt = cpu_req & ~dma_gnt.
  - At most one grant per cycle.
- Port mux:
  - The granted requester drives mem_addr2, mem_din2, mem_size and mem_sign.
  - mem_rden2 = granted & ~we; mem_we2 = granted & we.
  - With no grant: mem_rden2 = mem_we2 = 0, and the address/data/size/sign buses are driven to 0.
- Starvation counter wait_cnt (CNT_W bits, registered):
  - Increments when dma_req & ~dma_gnt.
  - Clears to 0 on dma_gnt, or when dma_req = 0.
  - Saturates at MAX_WAIT; no wrap.
- Read response tracking (registered):
  - rd_pending <= mem_rden2; rd_owner <= dma_gnt (0 = CPU, 1 = DMA).
  - Next cycle: cpu_rvalid = rd_pending & ~rd_owner; dma_rvalid = rd_pending & rd_owner.
  - The owner's rdata = mem_dout2; the other rdata = 0.
- Pipelining: a new grant may issue in the same cycle as the previous read's response. Back-to-back reads give one rvalid per cycle, in order.
- Stores produce no rvalid.
- Requesters hold all request fields stable while req = 1 and gnt = 0.
- Reset (RST = 1 at a clock edge):
  - wait_cnt = 0, rd_pending = 0, rd_owner = 0.
  - All rvalid outputs = 0 the next cycle; a read in flight at reset is dropped.
  - Grant outputs remain combinational from req while RST is high. The CPU FSM is in its reset state, so cpu_req = 0 in practice.
- Boundary conditions:
  - MAX_WAIT = 1: DMA wins every second contended cycle.
  - Both requesters idle: the port is idle and the counter is held at 0.
  - DMA drops dma_req while waiting: the counter clears.

Decomposition:
- Shared package otter_mem_pkg:
  - mem_size_t enum (BYTE = 0, HALF = 1, WORD = 2).
  - Struct mem_req_t {we, addr, din, size, sign}.
  - localparam IO_BASE = 32'h1100_0000 for future address decode.
- Sub-module: arb_starve_cnt, the saturating counter with force output. Everything else stays in the top.

Test Plan:
- CPU only: cpu_req = 1, we = 0, addr = 0x0000_6000 with mem_dout2 = 0xDEAD_BEEF next cycle -> cpu_gnt = 1 the same cycle, mem_rden2 = 1, cpu_rvalid = 1 and cpu_rdata = 0xDEAD_BEEF one cycle later, dma_rvalid = 0.
- DMA store alone: dma_req = 1, we = 1, addr = 0x8000, din = 0x1234_5678, size = 2 -> dma_gnt = 1, mem_we2 = 1, mem_addr2 = 0x8000, mem_din2 = 0x1234_5678, no rvalid.
- Contention, MAX_WAIT = 8: both request continuously -> CPU granted cycles 0–7, DMA granted cycle 8, wait_cnt back to 0 in cycle 9, pattern repeats every 9 cycles.
- Interleaved reads: CPU read, then DMA read on the following cycle -> cpu_rvalid in cycle 1 and dma_rvalid in cycle 2, each carrying its own mem_dout2 value, with no cross-delivery.
- Reset mid-read: CPU read granted in cycle 0, RST = 1 in cycle 1 -> cpu_rvalid = 0 in cycle 1 and cycle 2, wait_cnt = 0.
- DMA withdraw: DMA denied for 5 cycles, then dma_req = 0 for 1 cycle, then it re-requests under contention -> counter restarts at 0, and DMA is forced only after 8 further denied cycles.
